// File: rtl/count_ctrl.sv
// count_ctrl: run controller for a WIDTH-bit up-counter.
// It takes start/stop/pause commands and latches the terminal count and the mode at start.
// In one-shot mode it stops at the terminal count. In auto-reload mode it wraps to zero.
// It emits a one-cycle registered done pulse at the terminal count.
// Optional feature: define PRESCALE_EN to add a 'prescale' input. The counter then advances
// once every prescale+1 clocks while running.
module count_ctrl #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  input  logic                 reload,
  input  logic [WIDTH-1:0]     limit,
`ifdef PRESCALE_EN
  input  logic [PRE_WIDTH-1:0] prescale,
`endif
  output logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     limit_q, limit_d;
  logic                 reload_q, reload_d;
  logic                 done_q, done_d;
  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic [PRE_WIDTH-1:0] pre_lim;
  logic                 tick;
  logic                 at_limit;

`ifdef PRESCALE_EN
  logic [PRE_WIDTH-1:0] prescale_q, prescale_d;

  // Latch the prescale value together with limit/reload on an accepted start
  always_comb begin
    prescale_d = prescale_q;
    if (state_q == StIdle && start && !stop) begin
      prescale_d = prescale;
    end
  end

  // Prescale register, cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_d;
    end
  end

  assign pre_lim = prescale_q;
`else
  // Without prescaling the divider never leaves zero, so every running clock is a tick
  assign pre_lim = '0;
`endif

  assign tick     = (pre_q == pre_lim);
  assign at_limit = (q_q == limit_q);

  // Next-state, count and done-pulse logic; priority in RUN is stop > pause > tick
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    limit_d  = limit_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    pre_d    = pre_q;

    case (state_q)
      StIdle: begin
        // A stop in the same cycle as start cancels the start
        if (start && !stop) begin
          limit_d  = limit;
          reload_d = reload;
          q_d      = '0;
          pre_d    = '0;
          state_d  = StRun;
        end
      end

      StRun: begin
        if (stop) begin
          pre_d   = '0;
          state_d = StIdle;
        end else if (pause) begin
          state_d = StPause;
        end else if (tick) begin
          pre_d = '0;
          if (at_limit) begin
            done_d = 1'b1;
            if (reload_q) begin
              q_d = '0;
            end else begin
              state_d = StDone;
            end
          end else begin
            q_d = q_q + WIDTH'(1);
          end
        end else begin
          pre_d = pre_q + PRE_WIDTH'(1);
        end
      end

      StPause: begin
        // The resume edge only changes state; counting restarts on the following edge
        if (stop) begin
          pre_d   = '0;
          state_d = StIdle;
        end else if (!pause) begin
          state_d = StRun;
        end
      end

      StDone: begin
        // Start is deliberately ignored here; the done cycle always returns to idle
        pre_d   = '0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      q_q      <= '0;
      limit_q  <= '0;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
      pre_q    <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      limit_q  <= limit_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      pre_q    <= pre_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q == StRun) || (state_q == StPause);
  assign done = done_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: table-driven vectors plus hand-written multi-cycle
// sequences for async reset, auto-reload and (with PRESCALE_EN) prescaled counting.
module tb_count_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         pause;
  logic         reload;
  logic [W-1:0] limit;
  logic [W-1:0] q;
  logic         busy;
  logic         done;
`ifdef PRESCALE_EN
  logic [PW-1:0] prescale;
`endif

  always #5 clk = ~clk;

  count_ctrl #(
    .WIDTH    (W),
    .PRE_WIDTH(PW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .reload  (reload),
    .limit   (limit),
`ifdef PRESCALE_EN
    .prescale(prescale),
`endif
    .q       (q),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic         st;
    logic         sp;
    logic         pa;
    logic         rl;
    logic [W-1:0] lim;
    logic [W-1:0] eq;
    logic         eb;
    logic         ed;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic pa, input logic rl,
                     input logic [W-1:0] lim, input logic [W-1:0] eq, input logic eb,
                     input logic ed);
    vec_t v;
    v.st  = st;
    v.sp  = sp;
    v.pa  = pa;
    v.rl  = rl;
    v.lim = lim;
    v.eq  = eq;
    v.eb  = eb;
    v.ed  = ed;
    vecs.push_back(v);
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input int idx, input logic [W-1:0] eq,
                         input logic eb, input logic ed);
    chk({name, ".q"}, idx, 32'(q), 32'(eq));
    chk({name, ".busy"}, idx, 32'(busy), 32'(eb));
    chk({name, ".done"}, idx, 32'(done), 32'(ed));
  endtask

  initial begin
    int pulses;

    reset  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    pause  = 1'b0;
    reload = 1'b0;
    limit  = '0;
`ifdef PRESCALE_EN
    prescale = '0;
`endif

    // One-shot L=9; mid-run limit/reload/start changes must be ignored
    add(1, 0, 0, 0, 9, 0, 1, 0);
    for (int i = 1; i <= 9; i++) add((i == 3), 0, 0, 1, 3, W'(i), 1, 0);
    add(0, 0, 0, 0, 3, 9, 0, 1);
    add(0, 0, 0, 0, 3, 9, 0, 0);
    add(0, 0, 0, 0, 3, 9, 0, 0);
    // start and stop together in idle
    add(1, 1, 0, 0, 5, 9, 0, 0);
    add(0, 0, 0, 0, 5, 9, 0, 0);
    // Pause at q=4 for three edges, then one resume edge
    add(1, 0, 0, 0, 9, 0, 1, 0);
    for (int i = 1; i <= 4; i++) add(0, 0, 0, 0, 9, W'(i), 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 9, 4, 1, 0);
    add(0, 0, 0, 0, 9, 4, 1, 0);
    for (int i = 5; i <= 9; i++) add(0, 0, 0, 1, 9, W'(i), 1, 0);
    add(0, 0, 0, 0, 9, 9, 0, 1);
    add(0, 0, 0, 0, 9, 9, 0, 0);
    // Stop at q=7: back to idle, q held, no done
    add(1, 0, 0, 0, 9, 0, 1, 0);
    for (int i = 1; i <= 7; i++) add(0, 0, 0, 0, 9, W'(i), 1, 0);
    add(0, 1, 0, 0, 9, 7, 0, 0);
    add(0, 0, 0, 0, 9, 7, 0, 0);
    add(0, 0, 0, 0, 9, 7, 0, 0);
    // L=0 one-shot; start during the done cycle is ignored
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 5, 0, 0, 0);
    add(0, 0, 0, 0, 5, 0, 0, 0);
    // L=0 auto-reload: done every cycle until stopped
    add(1, 0, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 7, 0, 1, 1);
    add(0, 1, 0, 0, 7, 0, 0, 0);

    // Reset state
    step();
    step();
    chk_out("rst_hold", 0, 0, 0, 0);
    reset = 1'b1;
    step();
    chk_out("rst_idle", 0, 0, 0, 0);

    // Asynchronous reset mid-run at q=5 (one-shot, L=12)
    start = 1'b1;
    limit = 12;
    step();
    start = 1'b0;
    chk_out("async_start", 0, 0, 1, 0);
    repeat (5) step();
    chk_out("async_pre", 0, 5, 1, 0);
    #3;
    reset = 1'b0;
    #1;
    chk_out("async_clear", 0, 0, 0, 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("async_after", i, 0, 0, 0);
    end

    // Table-driven vectors
    foreach (vecs[i]) begin
      start  = vecs[i].st;
      stop   = vecs[i].sp;
      pause  = vecs[i].pa;
      reload = vecs[i].rl;
      limit  = vecs[i].lim;
      step();
      chk_out("vec", i, vecs[i].eq, vecs[i].eb, vecs[i].ed);
    end
    start  = 1'b0;
    stop   = 1'b0;
    pause  = 1'b0;
    reload = 1'b0;

    // Auto-reload L=15 for 50 cycles: period 16, done after edges k+16, k+32, k+48
    start  = 1'b1;
    reload = 1'b1;
    limit  = 15;
    step();
    start  = 1'b0;
    reload = 1'b0;
    limit  = 2;
    chk_out("auto_start", 0, 0, 1, 0);
    pulses = 0;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (done === 1'b1) pulses++;
      chk_out("auto", i, W'(i % 16), 1, (i % 16) == 0);
    end
    chk("auto_pulses", 0, 32'(pulses), 32'd3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_out("auto_stop", 0, 2, 0, 0);
    step();
    chk_out("auto_idle", 0, 2, 0, 0);

`ifdef PRESCALE_EN
    // Prescale P=2, L=3: q steps every 3 clocks, done after edge k+12
    prescale = 2;
    start    = 1'b1;
    limit    = 3;
    step();
    start    = 1'b0;
    prescale = '0;
    chk_out("pre_start", 0, 0, 1, 0);
    for (int i = 1; i <= 13; i++) begin
      step();
      chk_out("pre", i, (i >= 9) ? W'(3) : W'(i / 3), i < 12, i == 12);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
